// File: rtl/mem_arb_if.sv
// Bundle of client request/response and RAM-port signals for the two-client RAM arbiter.
// The slave modport is the arbiter's view; the master modport is the clients' and RAM's view.
interface mem_arb_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  clr_req;
  logic                  clr_done;
  logic                  busy;
  logic                  mem_rst;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wrdata;
  logic [DATA_WIDTH-1:0] mem_rddata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, clr_req, mem_rddata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, clr_done, busy,
           mem_rst, mem_we, mem_addr, mem_wrdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, clr_req, mem_rddata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, clr_done, busy,
           mem_rst, mem_we, mem_addr, mem_wrdata
  );
endinterface

// File: rtl/mem_arb_ctrl.sv
// Round-robin arbiter/sequencer putting two clients and a bulk-clear request onto one
// single-port synchronous RAM with registered read.
module mem_arb_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  mem_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    CLEAR  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic                  win_q, win_d;
  logic                  rd_q, rd_d;
  logic                  pend_q, pend_d;
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
  logic                  clr_done_q, clr_done_d;
  logic                  busy_q, busy_d;
  logic                  mem_rst_q, mem_rst_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wrdata_q, mem_wrdata_d;

  logic                  sel;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  always_comb begin
    // A tie goes to the client that did not win last; otherwise the lone requester wins.
    sel       = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    sel_we    = sel ? bus.we1 : bus.we0;
    sel_addr  = sel ? bus.addr1 : bus.addr0;
    sel_wdata = sel ? bus.wdata1 : bus.wdata0;

    state_d      = state_q;
    last_d       = last_q;
    win_d        = win_q;
    rd_d         = rd_q;
    pend_d       = pend_q | bus.clr_req;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    clr_done_d   = 1'b0;
    mem_rst_d    = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wrdata_d = mem_wrdata_q;

    unique case (state_q)
      IDLE: begin
        if (pend_q || bus.clr_req) begin
          state_d    = CLEAR;
          pend_d     = 1'b0;
          mem_rst_d  = 1'b1;
          clr_done_d = 1'b1;
        end else if (bus.req0 || bus.req1) begin
          state_d      = ACCESS;
          win_d        = sel;
          last_d       = sel;
          rd_d         = ~sel_we;
          gnt0_d       = ~sel;
          gnt1_d       = sel;
          mem_we_d     = sel_we;
          mem_addr_d   = sel_addr;
          mem_wrdata_d = sel_wdata;
        end
      end
      ACCESS: begin
        if (rd_q) begin
          state_d   = RDWAIT;
          rvalid0_d = ~win_q;
          rvalid1_d = win_q;
        end else begin
          state_d = IDLE;
        end
      end
      RDWAIT:  state_d = IDLE;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      win_q        <= 1'b0;
      rd_q         <= 1'b0;
      pend_q       <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      clr_done_q   <= 1'b0;
      busy_q       <= 1'b0;
      mem_rst_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wrdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      win_q        <= win_d;
      rd_q         <= rd_d;
      pend_q       <= pend_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      clr_done_q   <= clr_done_d;
      busy_q       <= busy_d;
      mem_rst_q    <= mem_rst_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wrdata_q <= mem_wrdata_d;
    end
  end

  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.rvalid0    = rvalid0_q;
  assign bus.rvalid1    = rvalid1_q;
  assign bus.clr_done   = clr_done_q;
  assign bus.busy       = busy_q;
  assign bus.mem_rst    = mem_rst_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wrdata = mem_wrdata_q;
  // Read data comes straight from the RAM's output register; qualified by rvalid.
  assign bus.rdata0     = bus.mem_rddata;
  assign bus.rdata1     = bus.mem_rddata;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Bench for mem_arb_ctrl: RAM model, queue-driven clients, timeline reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_mem_arb_ctrl;
  localparam int AW   = 3;
  localparam int DW   = 8;
  localparam int MAXC = 1024;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_init = 1'b1;
  always #5 clk = ~clk;

  mem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  mem_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Single-port RAM: registered read, synchronous bulk clear.
  logic [DW-1:0] ram [8];
  always @(posedge clk) begin
    if (bus.mem_rst || ram_init) begin
      for (int i = 0; i < 8; i++) ram[i] <= '0;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wrdata;
    end
    bus.mem_rddata <= ram[bus.mem_addr];
  end

  int n_pass = 0;
  int n_total = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Client drivers: each client presents the head of its queue until granted.
  cmd_t q0[$];
  cmd_t q1[$];
  initial begin
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    forever begin
      @(negedge clk);
      if (bus.gnt0 && q0.size() > 0) void'(q0.pop_front());
      if (bus.gnt1 && q1.size() > 0) void'(q1.pop_front());
      bus.req0 = (q0.size() > 0);
      if (q0.size() > 0) begin bus.we0 = q0[0].we; bus.addr0 = q0[0].addr; bus.wdata0 = q0[0].wd; end
      bus.req1 = (q1.size() > 0);
      if (q1.size() > 0) begin bus.we1 = q1[0].we; bus.addr1 = q1[0].addr; bus.wdata1 = q1[0].wd; end
    end
  end

  // Reference model: a timeline of expected outputs per cycle, filled in when a
  // transaction is scheduled. Cycle n is the interval following clock edge n.
  int            cyc = 0;
  bit            eg0 [MAXC];
  bit            eg1 [MAXC];
  bit            erv0[MAXC];
  bit            erv1[MAXC];
  bit            eclr[MAXC];
  bit            ebusy[MAXC];
  bit            ewe [MAXC];
  logic [DW-1:0] erd [MAXC];
  logic [AW-1:0] eaddr = '0;
  logic [DW-1:0] ewd = '0;
  logic [DW-1:0] mmem [8];
  bit            mlast = 1'b1;
  bit            mpend = 1'b0;
  int            idle_from = 0;

  initial begin
    bit w;
    for (int i = 0; i < 8; i++) mmem[i] = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (cyc < MAXC - 3) begin
        if (rst) begin
          mlast = 1'b1; mpend = 1'b0; idle_from = cyc; eaddr = '0; ewd = '0;
          for (int i = cyc; i < cyc + 3; i++) begin
            eg0[i] = 0; eg1[i] = 0; erv0[i] = 0; erv1[i] = 0; eclr[i] = 0; ebusy[i] = 0; ewe[i] = 0;
          end
        end else begin
          mpend = mpend | bus.clr_req;
          if (cyc - 1 >= idle_from) begin
            if (mpend) begin
              eclr[cyc] = 1; ebusy[cyc] = 1; mpend = 1'b0; idle_from = cyc + 1;
              for (int i = 0; i < 8; i++) mmem[i] = '0;
            end else if (bus.req0 || bus.req1) begin
              w = (bus.req0 && bus.req1) ? !mlast : bus.req1;
              mlast = w;
              if (w) begin eg1[cyc] = 1; ewe[cyc] = bus.we1; eaddr = bus.addr1; ewd = bus.wdata1; end
              else   begin eg0[cyc] = 1; ewe[cyc] = bus.we0; eaddr = bus.addr0; ewd = bus.wdata0; end
              ebusy[cyc] = 1;
              if (ewe[cyc]) begin
                mmem[eaddr] = ewd; idle_from = cyc + 1;
              end else begin
                if (w) erv1[cyc + 1] = 1; else erv0[cyc + 1] = 1;
                erd[cyc + 1] = mmem[eaddr]; ebusy[cyc + 1] = 1; idle_from = cyc + 2;
              end
            end
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, plus event logs for the directed checks.
  int g_cyc[$], g_cl[$], g_we[$], g_addr[$], g_wd[$];
  int rv_cyc[$], rv_cl[$], rv_d[$];
  int clr_cyc[$];
  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1 && cyc < MAXC - 3) begin
        chk("gnt0", int'(bus.gnt0), int'(eg0[cyc]));
        chk("gnt1", int'(bus.gnt1), int'(eg1[cyc]));
        chk("rvalid0", int'(bus.rvalid0), int'(erv0[cyc]));
        chk("rvalid1", int'(bus.rvalid1), int'(erv1[cyc]));
        chk("clr_done", int'(bus.clr_done), int'(eclr[cyc]));
        chk("mem_rst", int'(bus.mem_rst), int'(eclr[cyc]));
        chk("busy", int'(bus.busy), int'(ebusy[cyc]));
        chk("mem_we", int'(bus.mem_we), int'(ewe[cyc]));
        chk("mem_addr", int'(bus.mem_addr), int'(eaddr));
        chk("mem_wrdata", int'(bus.mem_wrdata), int'(ewd));
        if (erv0[cyc]) chk("rdata0", int'(bus.rdata0), int'(erd[cyc]));
        if (erv1[cyc]) chk("rdata1", int'(bus.rdata1), int'(erd[cyc]));
      end
      if (bus.gnt0 || bus.gnt1) begin
        g_cyc.push_back(cyc); g_cl.push_back(bus.gnt1 ? 1 : 0);
        g_we.push_back(int'(bus.mem_we)); g_addr.push_back(int'(bus.mem_addr));
        g_wd.push_back(int'(bus.mem_wrdata));
      end
      if (bus.rvalid0) begin rv_cyc.push_back(cyc); rv_cl.push_back(0); rv_d.push_back(int'(bus.rdata0)); end
      if (bus.rvalid1) begin rv_cyc.push_back(cyc); rv_cl.push_back(1); rv_d.push_back(int'(bus.rdata1)); end
      if (bus.clr_done) clr_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_t t;
    t.we = we; t.addr = a; t.wd = d;
    if (c == 0) q0.push_back(t); else q1.push_back(t);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    step();
    for (int i = 0; i < 40 && !done; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && !bus.req0 && !bus.req1 && !bus.busy) done = 1;
      else step();
    end
    if (!done) chk("wait_idle_timeout", 0, 1);
    step();
  endtask

  task automatic wait_gnt(input int c);
    bit done;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if ((c == 0) ? bus.gnt0 : bus.gnt1) done = 1;
    end
    if (!done) chk("wait_gnt_timeout", 0, 1);
  endtask

  initial begin
    int b, rb, cb;
    bus.clr_req = 0;
    step(); step();
    ram_init = 0;
    rst = 0;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_mem_addr", int'(bus.mem_addr), 0);
    chk("rst_gnt0", int'(bus.gnt0), 0);

    // Write 0xA5 to address 3 from client 0.
    b = g_cyc.size();
    push(0, 1'b1, 3'd3, 8'hA5);
    wait_idle();
    chk("t1_ngnt", g_cyc.size() - b, 1);
    if (g_cyc.size() > b) begin
      chk("t1_client", g_cl[b], 0);
      chk("t1_we", g_we[b], 1);
      chk("t1_addr", g_addr[b], 3);
      chk("t1_wdata", g_wd[b], 8'hA5);
    end

    // Client 1 reads it back.
    b = g_cyc.size(); rb = rv_cyc.size();
    push(1, 1'b0, 3'd3, 8'h00);
    wait_idle();
    chk("t2_nrv", rv_cyc.size() - rb, 1);
    if (g_cyc.size() > b && rv_cyc.size() > rb) begin
      chk("t2_client", g_cl[b], 1);
      chk("t2_we", g_we[b], 0);
      chk("t2_rv_client", rv_cl[rb], 1);
      chk("t2_rdata", rv_d[rb], 8'hA5);
      chk("t2_rv_lat", rv_cyc[rb] - g_cyc[b], 1);
    end

    // Both clients contend from reset: strict alternation, one grant per 2 cycles.
    rst = 1; step(); rst = 0;
    b = g_cyc.size();
    push(0, 1'b1, 3'd0, 8'h11); push(0, 1'b1, 3'd1, 8'h22);
    push(1, 1'b1, 3'd2, 8'h33); push(1, 1'b1, 3'd4, 8'h44);
    wait_idle();
    chk("t3_ngnt", g_cyc.size() - b, 4);
    if (g_cyc.size() >= b + 4) begin
      chk("t3_order0", g_cl[b], 0);
      chk("t3_order1", g_cl[b+1], 1);
      chk("t3_order2", g_cl[b+2], 0);
      chk("t3_order3", g_cl[b+3], 1);
      for (int i = 0; i < 3; i++) chk("t3_spacing", g_cyc[b+i+1] - g_cyc[b+i], 2);
    end

    // Clear requested (twice) while a read is in flight: read completes, one clear follows.
    rb = rv_cyc.size(); cb = clr_cyc.size();
    push(0, 1'b0, 3'd3, 8'h00);
    wait_gnt(0);
    bus.clr_req = 1; step(); step();
    bus.clr_req = 0;
    wait_idle();
    chk("t4_nrv", rv_cyc.size() - rb, 1);
    chk("t4_nclr", clr_cyc.size() - cb, 1);
    if (rv_cyc.size() > rb && clr_cyc.size() > cb) begin
      chk("t4_rdata", rv_d[rb], 8'hA5);
      chk("t4_clr_after_rv", clr_cyc[cb] - rv_cyc[rb], 2);
    end
    rb = rv_cyc.size();
    push(1, 1'b0, 3'd3, 8'h00);
    wait_idle();
    if (rv_cyc.size() > rb) chk("t4_cleared", rv_d[rb], 0);
    else chk("t4_cleared_nrv", 0, 1);

    // Clear and a request in the same IDLE cycle: clear wins.
    b = g_cyc.size(); cb = clr_cyc.size();
    push(0, 1'b1, 3'd5, 8'h5A);
    step();
    bus.clr_req = 1; step();
    bus.clr_req = 0;
    wait_idle();
    chk("t5_nclr", clr_cyc.size() - cb, 1);
    if (g_cyc.size() > b && clr_cyc.size() > cb) begin
      chk("t5_client", g_cl[b], 0);
      chk("t5_gnt_after_clr", g_cyc[b] - clr_cyc[cb], 2);
    end

    // Reset during a read aborts it; next tie goes to client 0.
    rb = rv_cyc.size();
    push(1, 1'b0, 3'd0, 8'h00);
    wait_gnt(1);
    rst = 1; step(); rst = 0;
    chk("t6_busy", int'(bus.busy), 0);
    chk("t6_rvalid1", int'(bus.rvalid1), 0);
    step(); step();
    chk("t6_no_rv", rv_cyc.size() - rb, 0);
    b = g_cyc.size();
    push(0, 1'b1, 3'd6, 8'h66); push(1, 1'b1, 3'd7, 8'h77);
    wait_idle();
    if (g_cyc.size() >= b + 2) chk("t6_tie_client", g_cl[b], 0);
    else chk("t6_ngnt", g_cyc.size() - b, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
